wino_out_accum: RTL and testbench

Downstream stage of the Winograd PE. It accepts the PE's 6x6 post-transform output tiles and accumulates the partial sums across input channels for one output channel and tile position. After the last channel it saturates each result to 12 bits and streams the results to output memory, one element per write handshake. The memory address is computed as od·H·W + row·W + col, and positions outside the feature map are clipped.

---
 rtl/wino_pkg.sv | 35 +++
 rtl/wino_addr_gen.sv | 26 ++
 rtl/wino_out_accum.sv | 135 +++++++++++++
 tb/tb_wino_out_accum.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wino_pkg.sv
// Shared constants, enums and the 12-bit saturation helper for the Winograd
// output stages.
package wino_pkg;

   localparam int TILE   = 6;
   localparam int DATA_W = 12;
   localparam int ACC_W  = 20;
   localparam int ADDR_W = 16;
   localparam int DIM_W  = 9;

   typedef enum logic {
      SZ_6X6 = 1'b0,
      SZ_4X4 = 1'b1
   } size_type_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   function automatic logic signed [DATA_W-1:0] sat12(input logic signed [ACC_W-1:0] v);
      logic signed [ACC_W-1:0] hi;
      logic signed [ACC_W-1:0] lo;
      hi = ACC_W'(2047);
      lo = ACC_W'(-2048);
      if (v > hi)
         return DATA_W'(2047);
      else if (v < lo)
         return DATA_W'(-2048);
      else
         return v[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/wino_addr_gen.sv
// Combinational feature-map address and bounds check: od*H*W + row*W + col,
// evaluated wide and truncated to the memory address width.
module wino_addr_gen
   import wino_pkg::*;
(
   input  logic [7:0]        od,
   input  logic [DIM_W:0]    row,
   input  logic [DIM_W:0]    col,
   input  logic [DIM_W-1:0]  height,
   input  logic [DIM_W-1:0]  width,
   output logic [ADDR_W-1:0] addr,
   output logic              in_bounds
);

   logic [26:0] plane_off;
   logic [26:0] line_off;

   always_comb begin
      plane_off = 27'(od) * 27'(height) * 27'(width);
      line_off  = 27'(row) * 27'(width);
      addr      = ADDR_W'(plane_off + line_off + 27'(col));
      // row/col carry one extra bit so base+offset past 511 still reads as out of bounds
      in_bounds = (row < {1'b0, height}) && (col < {1'b0, width});
   end

endmodule

// File: rtl/wino_out_accum.sv
// Accumulates Winograd PE output tiles across input channels, then drains the
// saturated results to output memory one element per accepted write.
module wino_out_accum #(
   parameter int TILE   = wino_pkg::TILE,
   parameter int DATA_W = wino_pkg::DATA_W,
   parameter int ACC_W  = wino_pkg::ACC_W,
   parameter int ADDR_W = wino_pkg::ADDR_W,
   parameter int DIM_W  = wino_pkg::DIM_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_tile [0:TILE-1][0:TILE-1],
   input  logic                     in_size_type,
   input  logic [DIM_W-1:0]         in_row_base,
   input  logic [DIM_W-1:0]         in_col_base,
   input  logic [7:0]               in_od,
   input  logic                     in_last,
   input  logic [DIM_W-1:0]         total_height,
   input  logic [DIM_W-1:0]         total_width,
   output logic                     mem_wr_en,
   input  logic                     mem_wr_ready,
   output logic [ADDR_W-1:0]        mem_wr_addr,
   output logic signed [DATA_W-1:0] mem_wr_data,
   output logic                     tile_done,
   output logic                     busy
);
   import wino_pkg::*;

   state_e                  state_q;
   size_type_e              size_q;
   logic [DIM_W-1:0]        row_base_q;
   logic [DIM_W-1:0]        col_base_q;
   logic [7:0]              od_q;
   logic [2:0]              r_q;
   logic [2:0]              c_q;
   logic signed [ACC_W-1:0] acc [0:TILE-1][0:TILE-1];

   logic [2:0]        last_idx;
   logic [DIM_W:0]    cur_row;
   logic [DIM_W:0]    cur_col;
   logic [ADDR_W-1:0] gen_addr;
   logic              in_bounds;
   logic              beat;
   logic              advance;

   // Handshakes: a tile beat transfers on a rising edge where in_valid && in_ready;
   // a write transfers where mem_wr_en && mem_wr_ready. A producer holds valid and
   // its payload until the transfer; this stage holds mem_wr_addr/data while stalled.
   assign beat     = in_valid && in_ready;
   assign last_idx = (size_q == SZ_4X4) ? 3'd3 : 3'd5;
   assign cur_row  = (DIM_W+1)'(row_base_q) + (DIM_W+1)'(r_q);
   assign cur_col  = (DIM_W+1)'(col_base_q) + (DIM_W+1)'(c_q);

   wino_addr_gen u_addr_gen (
      .od        (od_q),
      .row       (cur_row),
      .col       (cur_col),
      .height    (total_height),
      .width     (total_width),
      .addr      (gen_addr),
      .in_bounds (in_bounds)
   );

   // Out-of-map positions retire without a write, one cycle each.
   assign advance     = (state_q == ST_DRAIN) && (!in_bounds || mem_wr_ready);
   assign in_ready    = (state_q != ST_DRAIN);
   assign busy        = (state_q != ST_IDLE);
   assign mem_wr_en   = (state_q == ST_DRAIN) && in_bounds;
   assign mem_wr_addr = mem_wr_en ? gen_addr : '0;
   assign mem_wr_data = mem_wr_en ? sat12(acc[r_q][c_q]) : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         size_q     <= SZ_6X6;
         row_base_q <= '0;
         col_base_q <= '0;
         od_q       <= '0;
         r_q        <= '0;
         c_q        <= '0;
         tile_done  <= 1'b0;
         for (int i = 0; i < TILE; i++)
            for (int j = 0; j < TILE; j++)
               acc[i][j] <= '0;
      end else begin
         tile_done <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (beat) begin
                  size_q     <= size_type_e'(in_size_type);
                  row_base_q <= in_row_base;
                  col_base_q <= in_col_base;
                  od_q       <= in_od;
                  for (int i = 0; i < TILE; i++)
                     for (int j = 0; j < TILE; j++)
                        acc[i][j] <= ACC_W'(in_tile[i][j]);
                  state_q <= in_last ? ST_DRAIN : ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (beat) begin
                  for (int i = 0; i < TILE; i++)
                     for (int j = 0; j < TILE; j++)
                        acc[i][j] <= acc[i][j] + ACC_W'(in_tile[i][j]);
                  if (in_last)
                     state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (advance) begin
                  if (c_q == last_idx) begin
                     c_q <= '0;
                     if (r_q == last_idx) begin
                        r_q       <= '0;
                        state_q   <= ST_IDLE;
                        tile_done <= 1'b1;
                        for (int i = 0; i < TILE; i++)
                           for (int j = 0; j < TILE; j++)
                              acc[i][j] <= '0;
                     end else begin
                        r_q <= r_q + 3'd1;
                     end
                  end else begin
                     c_q <= c_q + 3'd1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wino_out_accum.sv
// Directed bench for wino_out_accum: drain ordering, saturation, clipping,
// write back-pressure, address wrap and reset during drain.
module tb_wino_out_accum;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic signed [11:0] in_tile [0:5][0:5];
   logic              in_size_type = 1'b0;
   logic [8:0]        in_row_base = '0;
   logic [8:0]        in_col_base = '0;
   logic [7:0]        in_od = '0;
   logic              in_last = 1'b0;
   logic [8:0]        total_height = 9'd8;
   logic [8:0]        total_width = 9'd8;
   logic              mem_wr_en;
   logic              mem_wr_ready = 1'b1;
   logic [15:0]       mem_wr_addr;
   logic signed [11:0] mem_wr_data;
   logic              tile_done;
   logic              busy;

   int n_checks = 0;
   int n_fail = 0;

   logic [15:0] got_addr[$];
   logic [11:0] got_data[$];
   int          got_cyc[$];
   logic [15:0] exp_addr_q[$];
   logic [11:0] exp_data_q[$];
   int          drain_cycles;
   int          stable_err;
   int          ready_in_drain;

   wino_out_accum dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_tile      (in_tile),
      .in_size_type (in_size_type),
      .in_row_base  (in_row_base),
      .in_col_base  (in_col_base),
      .in_od        (in_od),
      .in_last      (in_last),
      .total_height (total_height),
      .total_width  (total_width),
      .mem_wr_en    (mem_wr_en),
      .mem_wr_ready (mem_wr_ready),
      .mem_wr_addr  (mem_wr_addr),
      .mem_wr_data  (mem_wr_data),
      .tile_done    (tile_done),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic load_tile(input int v, input bit ramp);
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++)
            in_tile[i][j] = 12'(v + (ramp ? i * 6 + j : 0));
   endtask

   // Called at #1 after an edge; returns at #1 after the accepting edge.
   task automatic drive_beat(input int v, input bit ramp, input bit sz, input int rb,
                             input int cb, input int od, input bit last);
      load_tile(v, ramp);
      in_size_type = sz;
      in_row_base  = 9'(rb);
      in_col_base  = 9'(cb);
      in_od        = 8'(od);
      in_last      = last;
      in_valid     = 1'b1;
      for (int k = 0; k < 100 && !in_ready; k++) begin
         @(posedge clk); #1;
      end
      if (!in_ready) begin
         n_checks++; n_fail++;
         $display("FAIL beat_accept: in_ready=%0b required 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Records accepted writes until tile_done; stalls the first 'stalls' write cycles.
   task automatic capture(input int stalls, input int budget);
      int          left;
      bit          prev_stall;
      bit          done_seen;
      logic [15:0] pa;
      logic [11:0] pd;
      left = stalls; prev_stall = 0; done_seen = 0; pa = '0; pd = '0;
      got_addr.delete(); got_data.delete(); got_cyc.delete();
      drain_cycles = -1; stable_err = 0; ready_in_drain = 0;
      for (int cyc = 0; cyc < budget; cyc++) begin
         if (tile_done) begin
            done_seen = 1;
            drain_cycles = cyc;
            break;
         end
         if (in_ready) ready_in_drain++;
         if (prev_stall && (mem_wr_addr !== pa || mem_wr_data !== pd)) stable_err++;
         if (mem_wr_en && left > 0) begin
            mem_wr_ready = 1'b0;
            left--;
            prev_stall = 1;
            pa = mem_wr_addr;
            pd = mem_wr_data;
         end else begin
            mem_wr_ready = 1'b1;
            prev_stall = 0;
         end
         if (mem_wr_en && mem_wr_ready) begin
            got_addr.push_back(mem_wr_addr);
            got_data.push_back(mem_wr_data);
            got_cyc.push_back(cyc);
         end
         @(posedge clk); #1;
      end
      mem_wr_ready = 1'b1;
      if (!done_seen) begin
         n_checks++; n_fail++;
         $display("FAIL capture_timeout: no tile_done within %0d cycles", budget);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({in_ready, mem_wr_en, tile_done, busy} !== 4'b1000) begin
         n_fail++;
         $display("FAIL reset_ctrl: ready/en/done/busy=%b required 1000",
                  {in_ready, mem_wr_en, tile_done, busy});
      end
      n_checks++;
      if (mem_wr_addr !== 16'd0 || mem_wr_data !== 12'd0) begin
         n_fail++;
         $display("FAIL reset_data: addr=%0d data=%0d required 0 0", mem_wr_addr, mem_wr_data);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset_idle: busy=%b in_ready=%b required 0 1", busy, in_ready);
      end
   endtask

   task automatic test_single_4x4();
      total_height = 9'd8; total_width = 9'd8;
      drive_beat(5, 0, 1, 0, 0, 0, 1);
      capture(0, 100);
      n_checks++;
      if (drain_cycles !== 16) begin
         n_fail++;
         $display("FAIL single_drain_len: got %0d required 16", drain_cycles);
      end
      n_checks++;
      if (got_addr.size() !== 16) begin
         n_fail++;
         $display("FAIL single_write_count: got %0d required 16", got_addr.size());
      end
      exp_addr_q.delete();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            exp_addr_q.push_back(16'(r * 8 + c));
      for (int k = 0; k < 16 && k < got_addr.size(); k++) begin
         n_checks++;
         if (got_addr[k] !== exp_addr_q[k] || got_data[k] !== 12'd5 || got_cyc[k] !== k) begin
            n_fail++;
            $display("FAIL single_write[%0d]: addr=%0d data=%0d cyc=%0d required %0d 5 %0d",
                     k, got_addr[k], got_data[k], got_cyc[k], exp_addr_q[k], k);
         end
      end
      n_checks++;
      if (busy !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL single_idle_at_done: busy=%b in_ready=%b required 0 1", busy, in_ready);
      end
   endtask

   task automatic test_saturate();
      int          vals [3];
      logic [11:0] exps [3];
      vals = '{1000, -1000, 300};
      exps = '{12'(2047), 12'(-2048), 12'(900)};
      total_height = 9'd8; total_width = 9'd8;
      for (int t = 0; t < 3; t++) begin
         drive_beat(vals[t], 0, 1, 0, 0, 0, 0);
         n_checks++;
         if (busy !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_accum_state[%0d]: busy=%b in_ready=%b required 1 1", t, busy, in_ready);
         end
         // Later beats carry different size/base/od; the latched ones must win.
         drive_beat(vals[t], 0, 0, 4, 4, 5, 0);
         drive_beat(vals[t], 0, 0, 4, 4, 5, 1);
         capture(0, 100);
         n_checks++;
         if (got_addr.size() !== 16 || drain_cycles !== 16) begin
            n_fail++;
            $display("FAIL sat_count[%0d]: writes=%0d cycles=%0d required 16 16",
                     t, got_addr.size(), drain_cycles);
         end
         for (int k = 0; k < got_addr.size(); k++) begin
            n_checks++;
            if (got_data[k] !== exps[t] || got_addr[k] !== 16'((k / 4) * 8 + k % 4)) begin
               n_fail++;
               $display("FAIL sat_write[%0d][%0d]: addr=%0d data=%0d required %0d %0d",
                        t, k, got_addr[k], $signed(got_data[k]), (k / 4) * 8 + k % 4, $signed(exps[t]));
            end
         end
      end
   endtask

   task automatic test_clip();
      total_height = 9'd8; total_width = 9'd8;
      drive_beat(100, 1, 0, 4, 4, 0, 1);
      capture(0, 100);
      n_checks++;
      if (drain_cycles !== 36 || got_addr.size() !== 16) begin
         n_fail++;
         $display("FAIL clip_count: cycles=%0d writes=%0d required 36 16", drain_cycles, got_addr.size());
      end
      exp_addr_q.delete(); exp_data_q.delete();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            exp_addr_q.push_back(16'((4 + r) * 8 + 4 + c));
            exp_data_q.push_back(12'(100 + r * 6 + c));
         end
      for (int k = 0; k < 16 && k < got_addr.size(); k++) begin
         n_checks++;
         if (got_addr[k] !== exp_addr_q[k] || got_data[k] !== exp_data_q[k]) begin
            n_fail++;
            $display("FAIL clip_write[%0d]: addr=%0d data=%0d required %0d %0d",
                     k, got_addr[k], got_data[k], exp_addr_q[k], exp_data_q[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      total_height = 9'd8; total_width = 9'd8;
      drive_beat(50, 1, 1, 0, 0, 0, 1);
      // Next group is offered throughout the drain and must wait for IDLE.
      load_tile(7, 0);
      in_size_type = 1'b1; in_row_base = '0; in_col_base = '0; in_od = '0;
      in_last = 1'b1; in_valid = 1'b1;
      capture(3, 100);
      n_checks++;
      if (drain_cycles !== 19 || stable_err !== 0 || ready_in_drain !== 0) begin
         n_fail++;
         $display("FAIL stall_drain: cycles=%0d unstable=%0d ready_hi=%0d required 19 0 0",
                  drain_cycles, stable_err, ready_in_drain);
      end
      n_checks++;
      if (got_addr.size() !== 16) begin
         n_fail++;
         $display("FAIL stall_write_count: got %0d required 16", got_addr.size());
      end
      for (int k = 0; k < 16 && k < got_addr.size(); k++) begin
         n_checks++;
         if (got_addr[k] !== 16'((k / 4) * 8 + k % 4) || got_data[k] !== 12'(50 + (k / 4) * 6 + k % 4)
             || got_cyc[k] !== k + 3) begin
            n_fail++;
            $display("FAIL stall_write[%0d]: addr=%0d data=%0d cyc=%0d required %0d %0d %0d",
                     k, got_addr[k], got_data[k], got_cyc[k], (k / 4) * 8 + k % 4,
                     50 + (k / 4) * 6 + k % 4, k + 3);
         end
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL held_beat_ready: in_ready=%b required 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || mem_wr_en !== 1'b1) begin
         n_fail++;
         $display("FAIL held_beat_drain: busy=%b in_ready=%b en=%b required 1 0 1", busy, in_ready, mem_wr_en);
      end
      capture(0, 100);
      n_checks++;
      if (got_addr.size() !== 16 || drain_cycles !== 16) begin
         n_fail++;
         $display("FAIL held_beat_count: writes=%0d cycles=%0d required 16 16", got_addr.size(), drain_cycles);
      end
      for (int k = 0; k < got_data.size(); k++) begin
         n_checks++;
         if (got_data[k] !== 12'd7) begin
            n_fail++;
            $display("FAIL held_beat_data[%0d]: got %0d required 7", k, got_data[k]);
         end
      end
   endtask

   task automatic test_addr_wrap();
      total_height = 9'd256; total_width = 9'd256;
      drive_beat(1, 0, 1, 0, 0, 1, 1);
      capture(0, 100);
      n_checks++;
      if (got_addr.size() !== 16) begin
         n_fail++;
         $display("FAIL wrap_count: got %0d required 16", got_addr.size());
      end else begin
         n_checks++;
         if (got_addr[0] !== 16'd0 || got_addr[15] !== 16'd771) begin
            n_fail++;
            $display("FAIL wrap_addr: first=%0d last=%0d required 0 771", got_addr[0], got_addr[15]);
         end
      end
      total_height = 9'd16; total_width = 9'd16;
      drive_beat(1, 0, 1, 2, 3, 2, 1);
      capture(0, 100);
      n_checks++;
      if (got_addr.size() !== 16) begin
         n_fail++;
         $display("FAIL od2_count: got %0d required 16", got_addr.size());
      end else begin
         n_checks++;
         if (got_addr[0] !== 16'd547 || got_addr[15] !== 16'd598) begin
            n_fail++;
            $display("FAIL od2_addr: first=%0d last=%0d required 547 598", got_addr[0], got_addr[15]);
         end
      end
   endtask

   task automatic test_reset_mid_drain();
      int done_cnt;
      total_height = 9'd8; total_width = 9'd8;
      drive_beat(20, 0, 1, 0, 0, 0, 1);
      repeat (5) @(posedge clk);
      #3;
      n_checks++;
      if (mem_wr_en !== 1'b1 || mem_wr_addr !== 16'd9) begin
         n_fail++;
         $display("FAIL pre_reset_pos: en=%b addr=%0d required 1 9", mem_wr_en, mem_wr_addr);
      end
      reset = 1'b0;
      #1;
      n_checks++;
      if ({in_ready, mem_wr_en, tile_done, busy} !== 4'b1000 || mem_wr_addr !== 16'd0
          || mem_wr_data !== 12'd0) begin
         n_fail++;
         $display("FAIL mid_reset_outputs: ready/en/done/busy=%b addr=%0d data=%0d required 1000 0 0",
                  {in_ready, mem_wr_en, tile_done, busy}, mem_wr_addr, mem_wr_data);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      done_cnt = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (tile_done) done_cnt++;
      end
      n_checks++;
      if (done_cnt !== 0) begin
         n_fail++;
         $display("FAIL reset_no_done: pulses=%0d required 0", done_cnt);
      end
      drive_beat(9, 0, 1, 0, 0, 0, 1);
      capture(0, 100);
      n_checks++;
      if (got_addr.size() !== 16 || drain_cycles !== 16) begin
         n_fail++;
         $display("FAIL after_reset_count: writes=%0d cycles=%0d required 16 16", got_addr.size(), drain_cycles);
      end else begin
         n_checks++;
         if (got_addr[0] !== 16'd0 || got_data[0] !== 12'd9 || got_addr[15] !== 16'd27) begin
            n_fail++;
            $display("FAIL after_reset_writes: first=%0d/%0d last=%0d required 0/9 27",
                     got_addr[0], got_data[0], got_addr[15]);
         end
      end
   endtask

   initial begin
      load_tile(0, 0);
      test_reset();
      test_single_4x4();
      test_saturate();
      test_clip();
      test_back_to_back();
      test_addr_wrap();
      test_reset_mid_drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
